// File: rtl/f_fetch_unit_if.sv
// ============================================================================
// | Module      : f_fetch_unit_if                                            |
// | Description : Bundle of the F-stage signals: next-PC input, hazard       |
// |               stall, instruction-memory request/response and the F/D     |
// |               pipeline register outputs.                                 |
// |               master : the fetch unit                                    |
// |               slave  : its environment (NPC logic, hazard unit, imem, D) |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
`default_nettype none

interface f_fetch_unit_if;
  logic [31:0] npc;         // next PC from the D-stage NPC logic
  logic        d_stall;     // hazard-unit stall of F and D
  logic        imem_req;    // fetch request
  logic [31:0] imem_addr;   // fetch address (= f_pc)
  logic        imem_ready;  // imem_rdata valid for the current request
  logic [31:0] imem_rdata;  // fetched instruction word
  logic [31:0] f_pc;        // current fetch PC
  logic        f_busy;      // fetch outstanding
  logic [31:0] d_pc;        // F/D: PC of the instruction in D
  logic [31:0] d_instr;     // F/D: instruction in D
  logic        d_valid;     // F/D: holds a real instruction
  logic        f_adel;      // F/D: fetch address error

  modport master (
    input  npc, d_stall, imem_ready, imem_rdata,
    output imem_req, imem_addr, f_pc, f_busy, d_pc, d_instr, d_valid, f_adel
  );

  modport slave (
    output npc, d_stall, imem_ready, imem_rdata,
    input  imem_req, imem_addr, f_pc, f_busy, d_pc, d_instr, d_valid, f_adel
  );
endinterface

`default_nettype wire

// File: rtl/f_fetch_unit.sv
// ============================================================================
// | Module      : f_fetch_unit                                               |
// | Description : F stage. Holds F_PC, fetches from instruction memory with  |
// |               a ready handshake and loads the F/D pipeline register.     |
// |               A word that arrives while D is stalled is parked in a      |
// |               one-entry buffer (HOLD) until the stall clears.            |
// | Ports       : clk, reset_n (async, active-low)                           |
// |               bus (f_fetch_unit_if.master): npc, d_stall, imem_req,      |
// |               imem_addr, imem_ready, imem_rdata, f_pc, f_busy, d_pc,     |
// |               d_instr, d_valid, f_adel                                   |
// | Config      : FETCH_ADDR_CHECK_EN - when defined, misaligned or          |
// |               out-of-range fetches skip imem, load a nop and set f_adel. |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
`default_nettype none

module f_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  wire logic       clk,
  input  wire logic       reset_n,
  f_fetch_unit_if.master  bus
);

`ifdef FETCH_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  // One past the last legal byte address; 33 bits so a region ending at 4 GiB
  // does not wrap to zero.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t      state_q,   state_d;
  logic [31:0] f_pc_q,    f_pc_d;
  logic [31:0] d_pc_q,    d_pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic        d_valid_q, d_valid_d;
  logic        f_adel_q,  f_adel_d;
  logic [31:0] buf_q,     buf_d;      // parked instruction word
  logic [31:0] bpc_q,     bpc_d;      // PC of the parked word
  logic        badel_q,   badel_d;    // address-error flag of the parked word

  logic        addr_bad;
  logic        access_done;
  logic [31:0] fetch_word;

  // A bad address is treated as an access that completes instantly with a nop.
  assign addr_bad    = ADDR_CHECK &
                       ((f_pc_q[1:0] != 2'b00) ||
                        (f_pc_q < IM_BASE) ||
                        ({1'b0, f_pc_q} >= IM_LIMIT));
  assign access_done = bus.imem_ready | addr_bad;
  assign fetch_word  = addr_bad ? 32'h0 : bus.imem_rdata;

  always_comb begin
    state_d      = state_q;
    f_pc_d       = f_pc_q;
    d_pc_d       = d_pc_q;
    d_instr_d    = d_instr_q;
    d_valid_d    = d_valid_q;
    f_adel_d     = f_adel_q;
    buf_d        = buf_q;
    bpc_d        = bpc_q;
    badel_d      = badel_q;
    bus.imem_req = 1'b0;
    bus.f_busy   = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        bus.imem_req = ~addr_bad;
        bus.f_busy   = ~access_done;
        // d_stall wins over the F/D load; the arriving word goes to the buffer.
        if (access_done && !bus.d_stall) begin
          d_pc_d    = f_pc_q;
          d_instr_d = fetch_word;
          d_valid_d = 1'b1;
          f_adel_d  = addr_bad;
          f_pc_d    = bus.npc;
        end else if (access_done) begin
          buf_d   = fetch_word;
          bpc_d   = f_pc_q;
          badel_d = addr_bad;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!bus.d_stall) begin
          d_pc_d    = bpc_q;
          d_instr_d = buf_q;
          d_valid_d = 1'b1;
          f_adel_d  = badel_q;
          f_pc_d    = bus.npc;
          state_d   = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_FETCH;
      f_pc_q    <= RESET_PC;
      d_pc_q    <= 32'h0;
      d_instr_q <= 32'h0;
      d_valid_q <= 1'b0;
      f_adel_q  <= 1'b0;
      buf_q     <= 32'h0;
      bpc_q     <= 32'h0;
      badel_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      f_pc_q    <= f_pc_d;
      d_pc_q    <= d_pc_d;
      d_instr_q <= d_instr_d;
      d_valid_q <= d_valid_d;
      f_adel_q  <= f_adel_d;
      buf_q     <= buf_d;
      bpc_q     <= bpc_d;
      badel_q   <= badel_d;
    end
  end

  assign bus.imem_addr = f_pc_q;
  assign bus.f_pc      = f_pc_q;
  assign bus.d_pc      = d_pc_q;
  assign bus.d_instr   = d_instr_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.f_adel    = f_adel_q;

endmodule

`default_nettype wire

// File: tb/tb_f_fetch_unit.sv
// ============================================================================
// | Module      : tb_f_fetch_unit                                            |
// | Description : Self-checking bench for f_fetch_unit. Directed scenarios   |
// |               followed by a randomized run against a transaction-level   |
// |               model (fetched-but-undelivered words kept in a queue).     |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
`default_nettype none

module tb_f_fetch_unit;

  logic clk;
  logic reset_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  f_fetch_unit_if bus ();

  f_fetch_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        adel;
  } fetch_t;

  fetch_t      held[$];     // words fetched but not yet handed to D
  logic [31:0] m_fpc, m_dpc, m_dinstr;
  logic        m_dvalid, m_dadel, m_req, m_busy;

  function automatic logic addr_bad(input logic [31:0] a);
`ifdef FETCH_ADDR_CHECK_EN
    return (a[1:0] != 2'b00) || (a < 32'h3000) || (a >= 32'h3000 + 32'd16384);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    held.delete();
    m_fpc = 32'h3000; m_dpc = 0; m_dinstr = 0; m_dvalid = 0; m_dadel = 0;
  endtask

  // Drive one cycle of inputs at the falling edge and work out the expected
  // combinational outputs for that cycle.
  task automatic apply(input logic stall, input logic rdy,
                       input logic [31:0] nx, input logic [31:0] rd);
    @(negedge clk);
    bus.d_stall = stall; bus.imem_ready = rdy; bus.npc = nx; bus.imem_rdata = rd;
    if (held.size() != 0) begin
      m_req = 1'b0; m_busy = 1'b0;
    end else begin
      m_req  = !addr_bad(m_fpc);
      m_busy = !(rdy || addr_bad(m_fpc));
    end
    #1;
  endtask

  // Move the model across the rising edge and let the DUT do the same.
  task automatic advance();
    fetch_t f;
    if (held.size() != 0) begin
      if (!bus.d_stall) begin
        f = held.pop_front();
        m_dpc = f.pc; m_dinstr = f.word; m_dvalid = 1'b1; m_dadel = f.adel;
        m_fpc = bus.npc;
      end
    end else if (bus.imem_ready || addr_bad(m_fpc)) begin
      f.pc   = m_fpc;
      f.adel = addr_bad(m_fpc);
      f.word = f.adel ? 32'h0 : bus.imem_rdata;
      if (!bus.d_stall) begin
        m_dpc = f.pc; m_dinstr = f.word; m_dvalid = 1'b1; m_dadel = f.adel;
        m_fpc = bus.npc;
      end else begin
        held.push_back(f);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    // power-up reset still asserted
    n_cmp++; if (bus.f_pc !== 32'h3000) begin n_fail++; $display("FAIL rst_fpc got %h want %h", bus.f_pc, 32'h3000); end
    n_cmp++; if (bus.d_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dvalid got %b want 0", bus.d_valid); end
    n_cmp++; if (bus.f_adel !== 1'b0) begin n_fail++; $display("FAIL rst_adel got %b want 0", bus.f_adel); end
    @(negedge clk); reset_n = 1'b1; model_reset();
    // park a word in HOLD, then reset asynchronously mid-cycle
    apply(1'b1, 1'b1, 32'h3004, 32'h1234_5678);
    advance();
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_hold_req got %b want 0", bus.imem_req); end
    #2; reset_n = 1'b0; bus.imem_ready = 1'b0; bus.d_stall = 1'b0;
    #1;
    n_cmp++; if (bus.f_pc !== 32'h3000) begin n_fail++; $display("FAIL rst_mid_fpc got %h want %h", bus.f_pc, 32'h3000); end
    n_cmp++; if (bus.d_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dvalid got %b want 0", bus.d_valid); end
    n_cmp++; if (bus.d_instr !== 32'h0) begin n_fail++; $display("FAIL rst_mid_dinstr got %h want 0", bus.d_instr); end
    n_cmp++; if (bus.d_pc !== 32'h0) begin n_fail++; $display("FAIL rst_mid_dpc got %h want 0", bus.d_pc); end
    @(negedge clk); reset_n = 1'b1; model_reset();
    apply(1'b1, 1'b0, 32'h0, 32'h0);
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_rel_req got %b want 1", bus.imem_req); end
    n_cmp++; if (bus.imem_addr !== 32'h3000) begin n_fail++; $display("FAIL rst_rel_addr got %h want %h", bus.imem_addr, 32'h3000); end
    n_cmp++; if (bus.f_busy !== 1'b1) begin n_fail++; $display("FAIL rst_rel_busy got %b want 1", bus.f_busy); end
    advance();
  endtask

  task automatic test_zero_wait();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] pc;
      pc = 32'h3000 + 32'(4 * i);
      apply(1'b0, 1'b1, m_fpc + 32'd4, m_fpc ^ 32'h0000_A5A5);
      n_cmp++; if (bus.imem_addr !== pc) begin n_fail++; $display("FAIL zw_addr got %h want %h", bus.imem_addr, pc); end
      n_cmp++; if (bus.f_busy !== 1'b0) begin n_fail++; $display("FAIL zw_busy got %b want 0", bus.f_busy); end
      advance();
      n_cmp++; if (bus.d_pc !== pc) begin n_fail++; $display("FAIL zw_dpc got %h want %h", bus.d_pc, pc); end
      n_cmp++; if (bus.d_instr !== (pc ^ 32'h0000_A5A5)) begin n_fail++; $display("FAIL zw_dinstr got %h want %h", bus.d_instr, pc ^ 32'h0000_A5A5); end
      n_cmp++; if (bus.d_valid !== 1'b1) begin n_fail++; $display("FAIL zw_dvalid got %b want 1", bus.d_valid); end
    end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 32'hDEAD_0000, 32'h0);
      n_cmp++; if (bus.f_busy !== 1'b1) begin n_fail++; $display("FAIL ws_busy got %b want 1", bus.f_busy); end
      n_cmp++; if (bus.imem_addr !== 32'h3008) begin n_fail++; $display("FAIL ws_addr got %h want %h", bus.imem_addr, 32'h3008); end
      n_cmp++; if (bus.d_pc !== 32'h3004 || bus.d_valid !== 1'b1) begin n_fail++; $display("FAIL ws_dpc got %h/%b want 00003004/1", bus.d_pc, bus.d_valid); end
      advance();
    end
    apply(1'b0, 1'b1, 32'h300C, 32'h3008 ^ 32'h0000_A5A5);
    n_cmp++; if (bus.f_busy !== 1'b0) begin n_fail++; $display("FAIL ws_busy_rdy got %b want 0", bus.f_busy); end
    advance();
    n_cmp++; if (bus.d_pc !== 32'h3008) begin n_fail++; $display("FAIL ws_dpc_after got %h want %h", bus.d_pc, 32'h3008); end
  endtask

  task automatic test_stall_arrival();
    apply(1'b1, 1'b1, 32'h3010, 32'h300C ^ 32'h0000_A5A5);
    advance();
    // still stalled; a fresh ready/rdata must not overwrite the parked word
    apply(1'b1, 1'b1, 32'h0000_BAD0, 32'hFFFF_FFFF);
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL sa_req got %b want 0", bus.imem_req); end
    n_cmp++; if (bus.f_busy !== 1'b0) begin n_fail++; $display("FAIL sa_busy got %b want 0", bus.f_busy); end
    n_cmp++; if (bus.d_pc !== 32'h3008) begin n_fail++; $display("FAIL sa_dpc_hold got %h want %h", bus.d_pc, 32'h3008); end
    n_cmp++; if (bus.f_pc !== 32'h300C) begin n_fail++; $display("FAIL sa_fpc_hold got %h want %h", bus.f_pc, 32'h300C); end
    advance();
    apply(1'b0, 1'b0, 32'h3010, 32'h0);
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL sa_req2 got %b want 0", bus.imem_req); end
    advance();
    n_cmp++; if (bus.d_pc !== 32'h300C) begin n_fail++; $display("FAIL sa_dpc got %h want %h", bus.d_pc, 32'h300C); end
    n_cmp++; if (bus.d_instr !== (32'h300C ^ 32'h0000_A5A5)) begin n_fail++; $display("FAIL sa_dinstr got %h want %h", bus.d_instr, 32'h300C ^ 32'h0000_A5A5); end
    n_cmp++; if (bus.f_pc !== 32'h3010) begin n_fail++; $display("FAIL sa_fpc got %h want %h", bus.f_pc, 32'h3010); end
  endtask

  task automatic test_branch();
    apply(1'b0, 1'b1, 32'h3040, 32'h3010 ^ 32'h0000_A5A5);
    advance();
    n_cmp++; if (bus.imem_addr !== 32'h3040) begin n_fail++; $display("FAIL br_addr got %h want %h", bus.imem_addr, 32'h3040); end
    apply(1'b1, 1'b0, 32'h3080, 32'h0);
    advance();
    n_cmp++; if (bus.imem_addr !== 32'h3040) begin n_fail++; $display("FAIL br_stall_addr got %h want %h", bus.imem_addr, 32'h3040); end
    apply(1'b0, 1'b1, 32'h3044, 32'h3040 ^ 32'h0000_A5A5);
    advance();
    n_cmp++; if (bus.d_pc !== 32'h3040 || bus.f_pc !== 32'h3044) begin n_fail++; $display("FAIL br_dpc got %h/%h want 00003040/00003044", bus.d_pc, bus.f_pc); end
  endtask

  task automatic test_addr_check();
    apply(1'b0, 1'b1, 32'h3002, 32'h3044 ^ 32'h0000_A5A5);
    advance();
`ifdef FETCH_ADDR_CHECK_EN
    apply(1'b0, 1'b0, 32'h3100, 32'h1111_2222);
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL ac_req got %b want 0", bus.imem_req); end
    n_cmp++; if (bus.f_busy !== 1'b0) begin n_fail++; $display("FAIL ac_busy got %b want 0", bus.f_busy); end
    advance();
    n_cmp++; if (bus.d_instr !== 32'h0 || bus.f_adel !== 1'b1 || bus.d_valid !== 1'b1) begin n_fail++; $display("FAIL ac_load got %h/%b/%b want 00000000/1/1", bus.d_instr, bus.f_adel, bus.d_valid); end
`else
    apply(1'b0, 1'b1, 32'h3100, 32'h1111_2222);
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3002) begin n_fail++; $display("FAIL ac_req got %b/%h want 1/00003002", bus.imem_req, bus.imem_addr); end
    advance();
    n_cmp++; if (bus.d_instr !== 32'h1111_2222 || bus.f_adel !== 1'b0 || bus.d_pc !== 32'h3002) begin n_fail++; $display("FAIL ac_load got %h/%b/%h want 11112222/0/00003002", bus.d_instr, bus.f_adel, bus.d_pc); end
`endif
    // wrap-around of a plain 32-bit PC
    apply(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
    advance();
    apply(1'b0, 1'b1, m_fpc + 32'd4, 32'h0);
    advance();
    n_cmp++; if (bus.f_pc !== 32'h0) begin n_fail++; $display("FAIL ac_wrap got %h want 0", bus.f_pc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic        stall, rdy;
      logic [31:0] nx;
      int unsigned sel;
      stall = ($urandom_range(0, 3) == 0);
      rdy   = ($urandom_range(0, 2) != 0);
      sel   = $urandom_range(0, 9);
      if (sel < 6)       nx = m_fpc + 32'd4;
      else if (sel < 8)  nx = 32'h3000 + (32'($urandom_range(0, 4095)) << 2);
      else if (sel == 8) nx = 32'hFFFF_FFFC;
      else               nx = $urandom;
      apply(stall, rdy, nx, $urandom);
      n_cmp++; if (bus.imem_req !== m_req) begin n_fail++; $display("FAIL rnd_req cyc %0d got %b want %b", i, bus.imem_req, m_req); end
      n_cmp++; if (bus.f_busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy cyc %0d got %b want %b", i, bus.f_busy, m_busy); end
      n_cmp++; if (bus.imem_addr !== m_fpc || bus.f_pc !== m_fpc) begin n_fail++; $display("FAIL rnd_fpc cyc %0d got %h/%h want %h", i, bus.imem_addr, bus.f_pc, m_fpc); end
      n_cmp++; if (bus.d_pc !== m_dpc) begin n_fail++; $display("FAIL rnd_dpc cyc %0d got %h want %h", i, bus.d_pc, m_dpc); end
      n_cmp++; if (bus.d_instr !== m_dinstr) begin n_fail++; $display("FAIL rnd_dinstr cyc %0d got %h want %h", i, bus.d_instr, m_dinstr); end
      n_cmp++; if (bus.d_valid !== m_dvalid || bus.f_adel !== m_dadel) begin n_fail++; $display("FAIL rnd_flags cyc %0d got %b/%b want %b/%b", i, bus.d_valid, bus.f_adel, m_dvalid, m_dadel); end
      advance();
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.npc        = 32'h0;
    bus.d_stall    = 1'b0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_arrival();
    test_branch();
    test_addr_check();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
